// File: rtl/cic_pkg.sv
// Shared widths and constants for the CIC decimator output stage.
package cic_pkg;

   localparam int DIN_W_DEF  = 22;
   localparam int DOUT_W_DEF = 16;

   // Largest value representable in a w-bit two's-complement word.
   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   // Most negative value representable in a w-bit two's-complement word.
   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

   // Half an output LSB, added before the shift to round half-up.
   function automatic int round_const(input int shift);
      return 1 << (shift - 1);
   endfunction

endpackage

// File: rtl/cic_decim_out_fifo.sv
// Two-entry synchronous FIFO; dout is the registered head entry.
module sync_fifo2 #(
   parameter int W = 16
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem0;
   logic [W-1:0] mem1;
   logic [1:0]   cnt;
   logic         pop_ok;
   logic         push_ok;

   assign empty   = (cnt == 2'd0);
   assign full    = (cnt == 2'd2);
   assign pop_ok  = pop & ~empty;
   // A push into a full FIFO only lands when the head leaves in the same cycle.
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem0;

   // Storage and occupancy update; mem0 is always the head.
   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         mem0 <= '0;
         mem1 <= '0;
         cnt  <= 2'd0;
      end else if (clr) begin
         mem0 <= '0;
         mem1 <= '0;
         cnt  <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (empty) mem0 <= din;
               else       mem1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               mem0 <= mem1;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               if (full) begin
                  mem0 <= mem1;
                  mem1 <= din;
               end else begin
                  mem0 <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cic_decim_out.sv
// CIC output stage: decimate by R, round-half-up shift, saturate, buffer.
module cic_decim_out
   import cic_pkg::*;
#(
   parameter int DIN_W  = DIN_W_DEF,
   parameter int DOUT_W = DOUT_W_DEF,
   parameter int R      = 4,
   parameter int SHIFT  = 6
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     clr_i,
   input  logic                     en_i,
   input  logic signed [DIN_W-1:0]  data_i,
   input  logic                     ready_i,
   output logic                     valid_o,
   output logic signed [DOUT_W-1:0] data_o,
   output logic                     sat_o,
   output logic                     ovf_o
);

   localparam int S_W  = DIN_W + 1;
   localparam int PH_W = (R > 1) ? $clog2(R) : 1;

   localparam logic [PH_W-1:0]         PH_LAST = PH_W'(R - 1);
   localparam logic signed [S_W-1:0]   RND     = S_W'(round_const(SHIFT));
   localparam logic signed [S_W-1:0]   MAX_Q   = S_W'(sat_max(DOUT_W));
   localparam logic signed [S_W-1:0]   MIN_Q   = S_W'(sat_min(DOUT_W));
   localparam logic [DOUT_W-1:0]       MAX_D   = DOUT_W'(sat_max(DOUT_W));
   localparam logic [DOUT_W-1:0]       MIN_D   = DOUT_W'(sat_min(DOUT_W));

   logic [PH_W-1:0]         ph_cnt;
   logic                    keep;
   logic signed [S_W-1:0]   s_sum;
   logic signed [S_W-1:0]   q_next;
   logic                    v1;
   logic signed [S_W-1:0]   q1;
   logic                    clip;
   logic [DOUT_W-1:0]       d_sat;
   logic                    v2;
   logic [DOUT_W-1:0]       d2;
   logic                    sat_flag;
   logic                    ovf_flag;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic                    reject;
   logic [DOUT_W-1:0]       fifo_dout;

   // ph_cnt counts enabled samples remaining until the next keep; zero means keep now.
   assign keep   = en_i & (ph_cnt == '0);
   assign s_sum  = {data_i[DIN_W-1], data_i} + RND;
   assign q_next = s_sum >>> SHIFT;

   assign pop    = ~fifo_empty & ready_i;
   assign reject = v2 & fifo_full & ~pop;

   // Phase down-counter; reloads on every kept sample, idle cycles leave it alone.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ph_cnt <= '0;
      end else if (clr_i) begin
         ph_cnt <= '0;
      end else if (en_i) begin
         if (ph_cnt == '0) ph_cnt <= PH_LAST;
         else              ph_cnt <= ph_cnt - 1'b1;
      end
   end

   // Stage 1: register the rounded, shifted kept sample.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         v1 <= 1'b0;
         q1 <= '0;
      end else if (clr_i) begin
         v1 <= 1'b0;
      end else begin
         v1 <= keep;
         if (keep) q1 <= q_next;
      end
   end

   // Clip the shifted value into the output range.
   always_comb begin
      clip  = 1'b0;
      d_sat = q1[DOUT_W-1:0];
      if (q1 > MAX_Q) begin
         clip  = 1'b1;
         d_sat = MAX_D;
      end else if (q1 < MIN_Q) begin
         clip  = 1'b1;
         d_sat = MIN_D;
      end
   end

   // Stage 2: register the saturated value; this register feeds the FIFO push.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         v2 <= 1'b0;
         d2 <= '0;
      end else if (clr_i) begin
         v2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) d2 <= d_sat;
      end
   end

   // Sticky status flags.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else if (clr_i) begin
         sat_flag <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         if (v1 && clip) sat_flag <= 1'b1;
         if (reject)     ovf_flag <= 1'b1;
      end
   end

   sync_fifo2 #(
      .W (DOUT_W)
   ) u_fifo (
      .clk_sys (clk_i),
      .rst_b   (rstn_i),
      .clr     (clr_i),
      .push    (v2),
      .pop     (pop),
      .din     (d2),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign valid_o = ~fifo_empty;
   assign data_o  = fifo_dout;
   assign sat_o   = sat_flag;
   assign ovf_o   = ovf_flag;

endmodule

// File: tb/tb_cic_decim_out.sv
// Self-checking bench for cic_decim_out (R=4 instance plus an R=1 instance).
module tb_cic_decim_out;

   logic               clk;
   logic               rst_n;
   logic               clr;
   logic               en;
   logic signed [21:0] data;
   logic               ready;

   logic               valid4, sat4, ovf4;
   logic signed [15:0] dout4;
   logic               valid1, sat1, ovf1;
   logic signed [15:0] dout1;

   int checks   = 0;
   int failures = 0;

   cic_decim_out #(.DIN_W(22), .DOUT_W(16), .R(4), .SHIFT(6)) dut (
      .clk_i   (clk),
      .rstn_i  (rst_n),
      .clr_i   (clr),
      .en_i    (en),
      .data_i  (data),
      .ready_i (ready),
      .valid_o (valid4),
      .data_o  (dout4),
      .sat_o   (sat4),
      .ovf_o   (ovf4)
   );

   cic_decim_out #(.DIN_W(22), .DOUT_W(16), .R(1), .SHIFT(6)) dut1 (
      .clk_i   (clk),
      .rstn_i  (rst_n),
      .clr_i   (clr),
      .en_i    (en),
      .data_i  (data),
      .ready_i (ready),
      .valid_o (valid1),
      .data_o  (dout1),
      .sat_o   (sat1),
      .ovf_o   (ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model (R=4 instance) ----------------
   typedef struct {
      int val;
      bit clip;
      int kc;
   } pend_t;

   pend_t pend[$];
   int    mq[$];
   int    m_ph  = 0;
   bit    m_sat = 0;
   bit    m_ovf = 0;
   int    cyc   = 0;

   // floor((x + 32) / 64), done with plain integer arithmetic
   function automatic int ref_q(input int x);
      int v;
      v = x + 32;
      if (v >= 0) return v / 64;
      return -((-v + 63) / 64);
   endfunction

   task automatic model_reset();
      pend.delete();
      mq.delete();
      m_ph  = 0;
      m_sat = 0;
      m_ovf = 0;
   endtask

   task automatic model_step();
      bit    pop;
      int    q;
      pend_t p;
      cyc++;
      if (clr) begin
         model_reset();
      end else begin
         pop = (mq.size() > 0) && ready;
         if (pop) void'(mq.pop_front());
         foreach (pend[i])
            if (pend[i].kc == cyc - 1 && pend[i].clip) m_sat = 1;
         if (pend.size() > 0 && pend[0].kc == cyc - 2) begin
            if (mq.size() < 2) mq.push_back(pend[0].val);
            else               m_ovf = 1;
            void'(pend.pop_front());
         end
         if (en) begin
            if (m_ph == 0) begin
               q      = ref_q(int'(data));
               p.clip = (q > 32767) || (q < -32768);
               p.val  = (q > 32767) ? 32767 : (q < -32768) ? -32768 : q;
               p.kc   = cyc;
               pend.push_back(p);
            end
            m_ph = (m_ph + 1) % 4;
         end
      end
   endtask

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("model_valid", valid4, (mq.size() > 0) ? 1 : 0);
      if (mq.size() > 0) chk("model_data", dout4, mq[0]);
      chk("model_sat", sat4, m_sat);
      chk("model_ovf", ovf4, m_ovf);
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      model_check();
   endtask

   // ---------------- R=1 vector table ----------------
   typedef struct {
      logic signed [21:0] din;
      int                 exp;
      bit                 exp_sat;
   } vec_t;

   vec_t vt[6];

   initial begin
      vt[0] = '{din: 22'sd32,       exp: 1,      exp_sat: 1'b0};
      vt[1] = '{din: 22'sd31,       exp: 0,      exp_sat: 1'b0};
      vt[2] = '{din: -22'sd32,      exp: 0,      exp_sat: 1'b0};
      vt[3] = '{din: -22'sd33,      exp: -1,     exp_sat: 1'b0};
      vt[4] = '{din: 22'sd2097151,  exp: 32767,  exp_sat: 1'b1};
      vt[5] = '{din: -22'sd2097152, exp: -32768, exp_sat: 1'b0};

      rst_n = 1'b0;
      clr   = 1'b0;
      en    = 1'b0;
      data  = '0;
      ready = 1'b1;
      #3;
      chk("rst_valid", valid4, 0);
      chk("rst_data",  dout4,  0);
      chk("rst_sat",   sat4,   0);
      chk("rst_ovf",   ovf4,   0);
      chk("rst_valid_r1", valid1, 0);
      #10;
      rst_n = 1'b1;

      // rounding / saturation with R=1
      for (int i = 0; i < 6; i++) begin
         clr = 1'b1; tick(); clr = 1'b0;
         ready = 1'b1;
         en = 1'b1; data = vt[i].din; tick();
         en = 1'b0; data = '0; tick();
         tick();
         chk($sformatf("vec%0d_valid", i), valid1, 1);
         chk($sformatf("vec%0d_data", i),  dout1,  vt[i].exp);
         chk($sformatf("vec%0d_sat", i),   sat1,   vt[i].exp_sat);
         chk($sformatf("vec%0d_ovf", i),   ovf1,   0);
      end

      // ramp, en every cycle, ready high
      clr = 1'b1; tick(); clr = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 22; i++) begin
         en = 1'b1; data = 22'(64 * i); tick();
         chk($sformatf("ramp%0d_valid", i), valid4, (i >= 2 && (i - 2) % 4 == 0) ? 1 : 0);
         if (i >= 2 && (i - 2) % 4 == 0) chk($sformatf("ramp%0d_data", i), dout4, i - 2);
      end
      en = 1'b0;

      // enable gaps: only enabled cycles advance the phase
      clr = 1'b1; tick(); clr = 1'b0;
      for (int i = 0; i < 32; i++) begin
         en = (i % 2 == 0); data = 22'(64 * i); tick();
         chk($sformatf("gap%0d_valid", i), valid4, (i >= 2 && (i - 2) % 8 == 0) ? 1 : 0);
         if (i >= 2 && (i - 2) % 8 == 0) chk($sformatf("gap%0d_data", i), dout4, i - 2);
      end
      en = 1'b0;
      tick(); tick();

      // backpressure: A, B held, C dropped
      clr = 1'b1; tick(); clr = 1'b0;
      ready = 1'b0;
      for (int k = 0; k < 12; k++) begin
         en = 1'b1;
         data = (k == 0) ? 22'sd6400 : (k == 4) ? 22'sd12800 : (k == 8) ? 22'sd19200 : 22'sd0;
         tick();
         if (k == 9) chk("bp_ovf_before_c", ovf4, 0);
      end
      en = 1'b0; data = '0;
      tick(); tick(); tick();
      chk("bp_valid_a", valid4, 1);
      chk("bp_data_a",  dout4,  100);
      chk("bp_ovf",     ovf4,   1);
      ready = 1'b1; tick();
      chk("bp_valid_b", valid4, 1);
      chk("bp_data_b",  dout4,  200);
      tick();
      chk("bp_empty",   valid4, 0);

      // clear mid-stream: one sample in the FIFO, one in flight, both flags set
      ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         en = 1'b1;
         data = (k == 0) ? 22'sd2097151 : (k == 4) ? 22'sd576 : 22'sd0;
         tick();
      end
      en = 1'b0; data = '0;
      chk("clr_pre_valid", valid4, 1);
      chk("clr_pre_data",  dout4,  32767);
      chk("clr_pre_sat",   sat4,   1);
      chk("clr_pre_ovf",   ovf4,   1);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("clr_valid", valid4, 0);
      chk("clr_sat",   sat4,   0);
      chk("clr_ovf",   ovf4,   0);
      en = 1'b1; data = 22'sd448; tick();
      en = 1'b0; data = '0; tick(); tick();
      chk("clr_next_valid", valid4, 1);
      chk("clr_next_data",  dout4,  7);
      ready = 1'b1; tick();
      chk("clr_no_ghost", valid4, 0);

      // asynchronous reset mid-stream
      ready = 1'b0;
      clr = 1'b1; tick(); clr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         en = 1'b1;
         data = (k == 0) ? 22'sd2097151 : (k == 4) ? 22'sd576 : 22'sd0;
         tick();
      end
      en = 1'b0; data = '0;
      chk("rstm_pre_valid", valid4, 1);
      chk("rstm_pre_sat",   sat4,   1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rstm_valid", valid4, 0);
      chk("rstm_data",  dout4,  0);
      chk("rstm_sat",   sat4,   0);
      chk("rstm_ovf",   ovf4,   0);
      #2;
      rst_n = 1'b1;
      en = 1'b1; data = 22'sd448; tick();
      en = 1'b0; data = '0; tick(); tick();
      chk("rstm_next_valid", valid4, 1);
      chk("rstm_next_data",  dout4,  7);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         en    = ($urandom_range(0, 3) != 0);
         ready = ($urandom_range(0, 2) != 0);
         clr   = ($urandom_range(0, 79) == 0);
         case ($urandom_range(0, 7))
            0:       data = 22'sd2097151;
            1:       data = -22'sd2097152;
            2:       data = 22'($signed($urandom_range(0, 4000)) - 2000);
            default: data = 22'($urandom);
         endcase
         tick();
      end
      clr = 1'b0; en = 1'b0;
      tick(); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
